param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter DIV, default 1: number of enabled clk cycles per count tick, legal range 1..256.
REQ-003 Parameter SATURATE, default 0: 0 means wrap at the limits, 1 means hold at the limits.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 en  input  1  count enable; the prescaler advances only while en=1.
REQ-007 up  input  1  direction: 1 counts up, 0 counts down; sampled on the tick cycle.
REQ-008 load  input  1  synchronous load of load_val.
REQ-009 load_val  input  WIDTH  value written to count on load.
REQ-010 clr_ovf  input  1  clears the sticky ovf flag.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle wide per boundary event.
REQ-013 ovf  output  1  sticky boundary flag, registered.

Function
REQ-014 Priority SHALL be reset_n=0, then load, then the count tick.
REQ-015 On load=1: count=load_val and prescaler=0 on the next edge; tc=0 that cycle; ovf unchanged except by clr_ovf.
REQ-016 Prescaler: a counter of width clog2(DIV), minimum 1 bit.
  - Increments on each cycle with en=1 and load=0.
  - A tick occurs on the cycle the prescaler equals DIV-1; the prescaler then returns to 0.
  - If DIV=1, every enabled cycle is a tick.
REQ-017 en=0 SHALL freeze the prescaler and count; tc=0 while frozen.
REQ-018 Tick with up=1 and count<2^WIDTH-1: count SHALL increment by 1.
REQ-019 Tick with up=0 and count>0: count SHALL decrement by 1.
REQ-020 Up boundary (tick, up=1, count=2^WIDTH-1):
  - SATURATE=0: count=0.
  - SATURATE=1: count holds.
  - In both modes tc=1 for one cycle and ovf=1.
REQ-021 Down boundary (tick, up=0, count=0):
  - SATURATE=0: count=2^WIDTH-1.
  - SATURATE=1: count holds at 0.
  - In both modes tc=1 for one cycle and ovf=1.
REQ-022 In saturate mode, repeated ticks at a limit SHALL each produce a one-cycle tc pulse.
REQ-023 tc SHALL be 0 on every non-boundary cycle.
REQ-024 clr_ovf=1 SHALL clear ovf on the next edge; if a boundary event occurs in the same cycle, set wins and ovf=1.
REQ-025 A change of up between ticks SHALL NOT reset the prescaler; only the value of up at the tick matters.
REQ-026 All arithmetic SHALL be modulo 2^WIDTH; no output is combinationally derived from inputs.

Reset
REQ-027 While reset_n=0 at an edge: count=0, prescaler=0, tc=0, ovf=0.
REQ-028 Reset SHALL override load, en and clr_ovf in the same cycle.
REQ-029 Reset asserted mid-prescale SHALL discard the partial prescale; the first tick after release comes DIV enabled cycles later.
REQ-030 Outputs SHALL be defined (0) from the first edge with reset_n=0.

Verification
REQ-031 WIDTH=4, DIV=1, SATURATE=0, en=1, up=1, 16 cycles from reset -> count 1..15,0; tc=1 only on the cycle count wraps to 0; ovf=1 thereafter.
REQ-032 WIDTH=4, DIV=1, SATURATE=1, up=0 from count=0, 3 cycles -> count stays 0; tc pulses on each cycle; ovf=1; then clr_ovf=1 with no event -> ovf=0.
REQ-033 WIDTH=4, DIV=3, en=1, up=1 from reset -> count=1 after 3 cycles, 2 after 6; en=0 for 5 cycles mid-prescale -> count and phase frozen, and the next tick comes after the remaining enabled cycles.
REQ-034 load=1, load_val=14, with en=1 and up=1 in the same cycle -> count=14 with no tick that cycle; then wrap on the second following tick (14 -> 15 -> 0, tc=1).
REQ-035 At count=15 with a tick due, assert clr_ovf and the boundary together -> ovf=1; then assert reset_n=0 together with load=1 -> count=0, ovf=0, tc=0.
REQ-036 DIV=3, reset asserted after 2 enabled cycles and then released -> no tick until 3 further enabled cycles.

Source files
------------

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_counter
//  Description : Parameterised up/down counter with an enable-gated prescaler,
//                synchronous load, wrap or saturate behaviour at the limits,
//                a registered terminal-count pulse and a sticky boundary flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_counter #(
    parameter int WIDTH    = 4,   // counter width, 2..16
    parameter int DIV      = 1,   // enabled cycles per count tick, 1..256
    parameter int SATURATE = 0    // 0: wrap at limits, 1: hold at limits
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // A DIV of 1 still gets a one-bit prescaler that simply stays at zero,
    // which makes every enabled cycle a tick without a special case.
    localparam int                    c_ps_width = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_ps_width-1:0] c_ps_last  = c_ps_width'(DIV - 1);
    localparam logic [c_ps_width-1:0] c_ps_one   = c_ps_width'(1);
    localparam logic [WIDTH-1:0]      c_cnt_max  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]      c_cnt_min  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      c_cnt_one  = WIDTH'(1);
    localparam logic                  c_sat      = (SATURATE != 0);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range check
    // ------------------------------------------------------------------------
    generate
        if ((WIDTH < 2) || (WIDTH > 16) || (DIV < 1) || (DIV > 256) ||
            (SATURATE < 0) || (SATURATE > 1)) begin : g_param_check
            $error("param_counter: parameter out of legal range");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_ps_width-1:0] r_prescale;
    logic [WIDTH-1:0]      r_count;
    logic                  r_tc;
    logic                  r_ovf;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    logic                  w_tick;
    logic                  w_at_max;
    logic                  w_at_min;
    logic                  w_boundary;
    logic [c_ps_width-1:0] w_prescale_next;
    logic [WIDTH-1:0]      w_count_next;
    logic                  w_ovf_next;

    // Load has priority over counting, so a load cycle never ticks.
    assign w_tick     = en & ~load & (r_prescale == c_ps_last);
    assign w_at_max   = (r_count == c_cnt_max);
    assign w_at_min   = (r_count == c_cnt_min);
    // Boundary event: a tick that tries to step past either limit.
    assign w_boundary = w_tick & (up ? w_at_max : w_at_min);

    // Prescaler: cleared by load, frozen while disabled, returns to 0 on tick.
    always_comb begin
        w_prescale_next = r_prescale;
        if (load) begin
            w_prescale_next = '0;
        end else if (en) begin
            if (w_tick) begin
                w_prescale_next = '0;
            end else begin
                w_prescale_next = r_prescale + c_ps_one;
            end
        end
    end

    // Count: load wins; on a tick step in the sampled direction, holding at the
    // limit in saturate mode and wrapping modulo 2^WIDTH otherwise.
    always_comb begin
        w_count_next = r_count;
        if (load) begin
            w_count_next = load_val;
        end else if (w_tick) begin
            if (up) begin
                if (!(w_at_max && c_sat)) begin
                    w_count_next = r_count + c_cnt_one;
                end
            end else begin
                if (!(w_at_min && c_sat)) begin
                    w_count_next = r_count - c_cnt_one;
                end
            end
        end
    end

    // Sticky flag: a boundary event sets it and beats a simultaneous clear.
    always_comb begin
        w_ovf_next = r_ovf;
        if (w_boundary) begin
            w_ovf_next = 1'b1;
        end else if (clr_ovf) begin
            w_ovf_next = 1'b0;
        end
    end

    // State register with synchronous active-low reset overriding all inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prescale <= '0;
            r_count    <= '0;
            r_tc       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_prescale <= w_prescale_next;
            r_count    <= w_count_next;
            r_tc       <= w_boundary;
            r_ovf      <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------------
    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_counter
//  Description : Self-checking bench for param_counter. Three instances
//                (wrap/DIV=1, saturate/DIV=1, wrap/DIV=3) share one stimulus
//                stream and are compared every cycle against an arithmetic
//                reference model, with directed scenarios then random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_counter;

    localparam int c_n   = 3;
    localparam int c_max = 15;   // 2^4 - 1
    localparam int c_div [c_n] = '{1, 1, 3};
    localparam int c_sat [c_n] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       r_reset_n;
    logic       r_en;
    logic       r_up;
    logic       r_load;
    logic [3:0] r_load_val;
    logic       r_clr_ovf;

    logic [3:0] w_count [c_n];
    logic       w_tc    [c_n];
    logic       w_ovf   [c_n];

    int n_vec  = 0;
    int n_miss = 0;

    // Reference state: count value, position within the DIV-cycle window,
    // and the expected registered flags.
    int m_count [c_n];
    int m_phase [c_n];
    int m_tc    [c_n];
    int m_ovf   [c_n];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(4), .DIV(1), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(r_reset_n), .en(r_en), .up(r_up), .load(r_load),
        .load_val(r_load_val), .clr_ovf(r_clr_ovf),
        .count(w_count[0]), .tc(w_tc[0]), .ovf(w_ovf[0])
    );

    param_counter #(.WIDTH(4), .DIV(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(r_reset_n), .en(r_en), .up(r_up), .load(r_load),
        .load_val(r_load_val), .clr_ovf(r_clr_ovf),
        .count(w_count[1]), .tc(w_tc[1]), .ovf(w_ovf[1])
    );

    param_counter #(.WIDTH(4), .DIV(3), .SATURATE(0)) u_div3 (
        .clk(clk), .reset_n(r_reset_n), .en(r_en), .up(r_up), .load(r_load),
        .load_val(r_load_val), .clr_ovf(r_clr_ovf),
        .count(w_count[2]), .tc(w_tc[2]), .ovf(w_ovf[2])
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour for one rising edge, from the counter's rules.
    function automatic void model_edge();
        for (int i = 0; i < c_n; i++) begin
            if (!r_reset_n) begin
                m_count[i] = 0;
                m_phase[i] = 0;
                m_tc[i]    = 0;
                m_ovf[i]   = 0;
            end else if (r_load) begin
                m_count[i] = int'(r_load_val);
                m_phase[i] = 0;
                m_tc[i]    = 0;
                if (r_clr_ovf) m_ovf[i] = 0;
            end else if (!r_en) begin
                m_tc[i] = 0;
                if (r_clr_ovf) m_ovf[i] = 0;
            end else begin
                bit tick;
                bit hit;
                tick = (m_phase[i] == c_div[i] - 1);
                m_phase[i] = tick ? 0 : m_phase[i] + 1;
                hit = 0;
                if (tick) begin
                    if (r_up) begin
                        if (m_count[i] == c_max) begin
                            hit = 1;
                            m_count[i] = (c_sat[i] != 0) ? c_max : 0;
                        end else begin
                            m_count[i] = m_count[i] + 1;
                        end
                    end else begin
                        if (m_count[i] == 0) begin
                            hit = 1;
                            m_count[i] = (c_sat[i] != 0) ? 0 : c_max;
                        end else begin
                            m_count[i] = m_count[i] - 1;
                        end
                    end
                end
                m_tc[i] = hit ? 1 : 0;
                if (hit)            m_ovf[i] = 1;
                else if (r_clr_ovf) m_ovf[i] = 0;
            end
        end
    endfunction

    // Advance n clock edges, updating the model and comparing 1 ns after each.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            for (int i = 0; i < c_n; i++) begin
                check_val($sformatf("dut%0d count", i), int'(w_count[i]), m_count[i]);
                check_val($sformatf("dut%0d tc", i),    int'(w_tc[i]),    m_tc[i]);
                check_val($sformatf("dut%0d ovf", i),   int'(w_ovf[i]),   m_ovf[i]);
            end
        end
    endtask

    task automatic drive(input logic rn, input logic e, input logic u,
                         input logic ld, input logic [3:0] lv, input logic clr);
        r_reset_n  = rn;
        r_en       = e;
        r_up       = u;
        r_load     = ld;
        r_load_val = lv;
        r_clr_ovf  = clr;
    endtask

    initial begin
        for (int i = 0; i < c_n; i++) begin
            m_count[i] = 0; m_phase[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end

        // Reset overrides load/en/clr_ovf; outputs zero from the first edge.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b1);
        step(2);
        check_val("reset count", int'(w_count[0]), 0);
        check_val("reset ovf",   int'(w_ovf[1]),   0);

        // Free-running up count, DIV=1 wrap: 1..15 then 0 with a tc pulse.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(15);
        check_val("up15 count", int'(w_count[0]), 15);
        check_val("up15 tc",    int'(w_tc[0]),    0);
        step(1);
        check_val("wrap count", int'(w_count[0]), 0);
        check_val("wrap tc",    int'(w_tc[0]),    1);
        check_val("wrap ovf",   int'(w_ovf[0]),   1);
        check_val("sat hold",   int'(w_count[1]), 15);
        step(2);

        // Saturating down count from 0: holds, tc every tick; then clear.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(3);
        check_val("satdn count", int'(w_count[1]), 0);
        check_val("satdn tc",    int'(w_tc[1]),    1);
        check_val("satdn ovf",   int'(w_ovf[1]),   1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1);
        check_val("clr ovf", int'(w_ovf[1]), 0);

        // DIV=3 prescaling with a mid-prescale freeze.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(3);
        check_val("div3 first", int'(w_count[2]), 1);
        step(3);
        check_val("div3 second", int'(w_count[2]), 2);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step(5);
        check_val("div3 frozen", int'(w_count[2]), 2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        step(1);
        check_val("div3 pre", int'(w_count[2]), 2);
        step(1);
        check_val("div3 resume", int'(w_count[2]), 1);

        // Load beats a same-cycle tick; then two ticks to the wrap.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0);
        step(1);
        check_val("load count", int'(w_count[0]), 14);
        check_val("load tc",    int'(w_tc[0]),    0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(2);
        check_val("load wrap", int'(w_count[0]), 0);
        check_val("load wrap tc", int'(w_tc[0]), 1);

        // Clear coinciding with a boundary: set wins. Then reset beats load.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 1'b1);
        step(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        step(1);
        check_val("set wins ovf", int'(w_ovf[0]), 1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        step(1);
        check_val("rst>load count", int'(w_count[0]), 0);
        check_val("rst>load ovf",   int'(w_ovf[0]),   0);
        check_val("rst>load tc",    int'(w_tc[0]),    0);

        // Reset mid-prescale discards the partial window.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        step(2);
        check_val("rst discard", int'(w_count[2]), 0);
        step(1);
        check_val("rst tick", int'(w_count[2]), 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0));
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
